// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and the operand class type shared by the FP32 multiplier stages.
package fpu_pkg;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [7:0]  EXP_BIAS  = 8'd127;
  localparam logic [22:0] QNAN_FRAC = 23'h400000;

  localparam int FRAC_W = 23;
  localparam int SIG_W  = 24;
  localparam int PP_W   = 36;

  // Result class of an operand pair, decided before any multiplication happens.
  typedef enum logic [1:0] {
    NORM = 2'd0,
    ZERO = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class;

endpackage

// File: rtl/fmul_classify.sv
// fmul_classify: combinational special-case detection for an FP32 operand pair.
// Subnormals count as zero because they are flushed.
module fmul_classify
  import fpu_pkg::*;
(
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  output fp_class           cls_o,
  output logic              primal_o,
  output logic [7:0]        primal_exp_o,
  output logic [FRAC_W-1:0] primal_frac_o
);

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_zero = (a_i[30:23] == 8'h00);
  assign b_zero = (b_i[30:23] == 8'h00);
  assign a_inf  = (a_i[30:23] == EXP_MAX) && (a_i[22:0] == '0);
  assign b_inf  = (b_i[30:23] == EXP_MAX) && (b_i[22:0] == '0);
  assign a_nan  = (a_i[30:23] == EXP_MAX) && (a_i[22:0] != '0);
  assign b_nan  = (b_i[30:23] == EXP_MAX) && (b_i[22:0] != '0);

  // Priority chain: NaN, Inf*0, Inf, zero, then ordinary numbers.
  always_comb begin
    cls_o         = NORM;
    primal_o      = 1'b0;
    primal_exp_o  = 8'h00;
    primal_frac_o = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      cls_o         = NAN;
      primal_o      = 1'b1;
      primal_exp_o  = EXP_MAX;
      primal_frac_o = QNAN_FRAC;
    end else if (a_inf || b_inf) begin
      cls_o        = INF;
      primal_o     = 1'b1;
      primal_exp_o = EXP_MAX;
    end else if (a_zero || b_zero) begin
      cls_o    = ZERO;
      primal_o = 1'b1;
    end
  end

endmodule

// File: rtl/fmul_stage3.sv
// fmul_stage3: FP32 multiplier mantissa-product stage (S1 operands/class, S2 products).
// Splits the 24x24 significand product into c1 = Ah*Bm and c2 = Al*Bm.
// Optional: define FMUL_STAGE3_SKID_EN for a one-entry input skid buffer that
// makes in_ready a registered signal.
module fmul_stage3
  import fpu_pkg::*;
#(
  parameter int SPLIT = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  a,
  input  logic [31:0]                  b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sign,
  output logic [7:0]                   A_exp,
  output logic [7:0]                   B_exp,
  output logic                         primal,
  output logic [7:0]                   primal_exp,
  output logic [FRAC_W-1:0]            primal_frac,
  output logic [2*SIG_W-SPLIT-1:0]     c1,
  output logic [2*SIG_W-SPLIT-1:0]     c2
);

  localparam int PW = 2*SIG_W - SPLIT;
  localparam int HW = SIG_W - SPLIT;

  // Operand source into S1 (input port, or skid entry when one is buffered)
  logic        src_v;
  logic [31:0] src_a, src_b;

  logic s2_take, s2_load, s1_free, s1_load;

  fp_class           cls_c;
  logic              primal_c;
  logic [7:0]        pexp_c;
  logic [FRAC_W-1:0] pfrac_c;

  logic              s1_v_q, s1_v_d;
  logic [31:0]       s1_a_q, s1_b_q;
  fp_class           s1_cls_q;
  logic              s1_primal_q;
  logic [7:0]        s1_pexp_q;
  logic [FRAC_W-1:0] s1_pfrac_q;

  logic              out_valid_q, out_valid_d;
  logic              sign_q;
  logic [7:0]        a_exp_q, b_exp_q;
  logic              primal_q;
  logic [7:0]        primal_exp_q;
  logic [FRAC_W-1:0] primal_frac_q;
  logic [PW-1:0]     c1_q, c1_d, c2_q, c2_d;

  logic [SIG_W-1:0]  am, bm;
  logic [HW-1:0]     ah;
  logic [SPLIT-1:0]  al;

  fmul_classify u_classify (
    .a_i          (src_a),
    .b_i          (src_b),
    .cls_o        (cls_c),
    .primal_o     (primal_c),
    .primal_exp_o (pexp_c),
    .primal_frac_o(pfrac_c)
  );

  // A stage loads when empty or when its content leaves this cycle.
  assign s2_take = !out_valid_q || out_ready;
  assign s2_load = s1_v_q && s2_take;
  assign s1_free = !s1_v_q || s2_take;
  assign s1_load = src_v && s1_free;

`ifdef FMUL_STAGE3_SKID_EN
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_a_q, skid_b_q;

  assign in_ready = !skid_v_q;
  assign src_v    = skid_v_q || in_valid;
  assign src_a    = skid_v_q ? skid_a_q : a;
  assign src_b    = skid_v_q ? skid_b_q : b;

  // Skid fills when an accepted pair finds S1 blocked and drains once S1 frees.
  always_comb begin
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (s1_free) skid_v_d = 1'b0;
    end else if (in_valid && !s1_free) begin
      skid_v_d = 1'b1;
    end
  end

  // Skid entry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v_q <= 1'b0;
      skid_a_q <= '0;
      skid_b_q <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      if (!skid_v_q && in_valid && !s1_free) begin
        skid_a_q <= a;
        skid_b_q <= b;
      end
    end
  end
`else
  assign in_ready = s1_free;
  assign src_v    = in_valid;
  assign src_a    = a;
  assign src_b    = b;
`endif

  // Significands with hidden bit; subnormals already classified as zero.
  assign am = {(s1_a_q[30:23] != 8'h00), s1_a_q[22:0]};
  assign bm = {(s1_b_q[30:23] != 8'h00), s1_b_q[22:0]};
  assign ah = am[SIG_W-1:SPLIT];
  assign al = am[SPLIT-1:0];

  // Stage occupancy and the two partial products (forced to zero for specials).
  always_comb begin
    s1_v_d = s1_v_q;
    if (s1_load)      s1_v_d = 1'b1;
    else if (s2_load) s1_v_d = 1'b0;
    out_valid_d = out_valid_q;
    if (s2_load)        out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    c1_d = '0;
    c2_d = '0;
    if (s1_cls_q == NORM) begin
      c1_d = PW'(ah) * PW'(bm);
      c2_d = PW'(al) * PW'(bm);
    end
  end

  // S1: operands and classification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cls_q    <= NORM;
      s1_primal_q <= 1'b0;
      s1_pexp_q   <= '0;
      s1_pfrac_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      if (s1_load) begin
        s1_a_q      <= src_a;
        s1_b_q      <= src_b;
        s1_cls_q    <= cls_c;
        s1_primal_q <= primal_c;
        s1_pexp_q   <= pexp_c;
        s1_pfrac_q  <= pfrac_c;
      end
    end
  end

  // S2: result fields, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      sign_q        <= 1'b0;
      a_exp_q       <= '0;
      b_exp_q       <= '0;
      primal_q      <= 1'b0;
      primal_exp_q  <= '0;
      primal_frac_q <= '0;
      c1_q          <= '0;
      c2_q          <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        sign_q        <= s1_a_q[31] ^ s1_b_q[31];
        a_exp_q       <= s1_a_q[30:23];
        b_exp_q       <= s1_b_q[30:23];
        primal_q      <= s1_primal_q;
        primal_exp_q  <= s1_pexp_q;
        primal_frac_q <= s1_pfrac_q;
        c1_q          <= c1_d;
        c2_q          <= c2_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign sign        = sign_q;
  assign A_exp       = a_exp_q;
  assign B_exp       = b_exp_q;
  assign primal      = primal_q;
  assign primal_exp  = primal_exp_q;
  assign primal_frac = primal_frac_q;
  assign c1          = c1_q;
  assign c2          = c2_q;

endmodule

// File: tb/tb_fmul_stage3.sv
// tb_fmul_stage3: directed corner cases, backpressure, reset and random traffic
// against a behavioural reference model with an in-order scoreboard.
module tb_fmul_stage3;

`ifdef FMUL_STAGE3_SKID_EN
  localparam int HELD = 3;
`else
  localparam int HELD = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic        sign, primal;
  logic [7:0]  A_exp, B_exp, primal_exp;
  logic [22:0] primal_frac;
  logic [35:0] c1, c2;

  fmul_stage3 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign       (sign),
    .A_exp      (A_exp),
    .B_exp      (B_exp),
    .primal     (primal),
    .primal_exp (primal_exp),
    .primal_frac(primal_frac),
    .c1         (c1),
    .c2         (c2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [7:0]  aexp;
    logic [7:0]  bexp;
    logic        primal;
    logic [7:0]  pexp;
    logic [22:0] pfrac;
    logic [35:0] c1;
    logic [35:0] c2;
  } res_t;

  int   errs = 0;
  int   checks = 0;
  int   emitted = 0;
  res_t sb[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: IEEE class rules and plain integer products of the significands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t r;
    int unsigned ex = x[30:23];
    int unsigned ey = y[30:23];
    int unsigned fx = x[22:0];
    int unsigned fy = y[22:0];
    longint unsigned mx, my;
    bit xz = (ex == 0);
    bit yz = (ey == 0);
    bit xi = (ex == 255) && (fx == 0);
    bit yi = (ey == 255) && (fy == 0);
    bit xn = (ex == 255) && (fx != 0);
    bit yn = (ey == 255) && (fy != 0);
    r = '0;
    r.sign = x[31] ^ y[31];
    r.aexp = x[30:23];
    r.bexp = y[30:23];
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      r.primal = 1'b1; r.pexp = 8'hFF; r.pfrac = 23'h400000;
    end else if (xi || yi) begin
      r.primal = 1'b1; r.pexp = 8'hFF;
    end else if (xz || yz) begin
      r.primal = 1'b1;
    end else begin
      mx = longint'(fx) + 64'd8388608;
      my = longint'(fy) + 64'd8388608;
      r.c1 = 36'((mx / 4096) * my);
      r.c2 = 36'((mx % 4096) * my);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2: r[30:23] = 8'hFF;
      default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h80;
    endcase
    return r;
  endfunction

  // Monitor: scoreboard on every transfer, hold check on every stall.
  initial begin
    res_t e, cur, prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{sign, A_exp, B_exp, primal, primal_exp, primal_frac, c1, c2};
        if (prev_stall) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_fields", cur, prev);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            check("sign_exps", {sign, A_exp, B_exp}, {e.sign, e.aexp, e.bexp});
            check("primal_fields", {primal, primal_exp, primal_frac}, {e.primal, e.pexp, e.pfrac});
            check("c1", c1, e.c1);
            check("c2", c2, e.c2);
            emitted++;
          end
        end
        if (in_valid && in_ready) sb.push_back(model(a, b));
        prev_stall = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  // Single operation through an empty pipe with literal expectations.
  task automatic directed(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [35:0] e1, input logic [35:0] e2, input logic [31:0] epr);
    @(posedge clk); #1;
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 1'b1);
    check({tag, "_aexp"}, A_exp, xa[30:23]);
    check({tag, "_c1"}, c1, e1);
    check({tag, "_c2"}, c2, e2);
    check({tag, "_primal"}, {primal, primal_exp, primal_frac}, epr);
    $display("directed %s a=%08h b=%08h c1=%09h c2=%09h primal=%0d", tag, xa, xb, c1, c2, primal);
  endtask

  initial begin
    logic [31:0] bp_a[6], bp_b[6];
    int idx, e0, nacc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_c1c2", {c1, c2}, 72'd0);
    check("rst_primal", primal, 1'b0);
    #10 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    directed("one",   32'h3F800000, 32'h3F800000, 36'h400000000, 36'h0,         {1'b0, 8'h00, 23'h0});
    directed("onep5", 32'h3FC00000, 32'h3FC00000, 36'h900000000, 36'h0,         {1'b0, 8'h00, 23'h0});
    directed("lowh",  32'h3F800FFF, 32'h3F800000, 36'h400000000, 36'h7FF800000, {1'b0, 8'h00, 23'h0});
    directed("infz",  32'h7F800000, 32'h00000000, 36'h0, 36'h0, {1'b1, 8'hFF, 23'h400000});
    directed("zinf",  32'h00000000, 32'hFF800000, 36'h0, 36'h0, {1'b1, 8'hFF, 23'h400000});
    directed("inf1",  32'h7F800000, 32'h3F800000, 36'h0, 36'h0, {1'b1, 8'hFF, 23'h0});
    directed("sub",   32'h00000001, 32'h40490FDB, 36'h0, 36'h0, {1'b1, 8'h00, 23'h0});
    directed("nan",   32'h3F800000, 32'h7FC00001, 36'h0, 36'h0, {1'b1, 8'hFF, 23'h400000});

    // Back-to-back with a free consumer: in_ready must never drop.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a = rand_op(); b = rand_op(); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1 in_valid = 1'b0;

    // Backpressure: 6 ops, consumer stalled for the first 4 cycles.
    for (int i = 0; i < 6; i++) begin bp_a[i] = rand_op(); bp_b[i] = rand_op(); end
    repeat (3) @(posedge clk);
    e0 = emitted; idx = 0;
    for (int cyc = 0; cyc < 60 && (idx < 6 || emitted - e0 < 6); cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 4);
      in_valid  = (idx < 6);
      if (idx < 6) begin a = bp_a[idx]; b = bp_b[idx]; end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (cyc == 3) begin
        check("bp_accepted", idx, HELD);
        check("bp_in_ready_low", in_ready, 1'b0);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    check("bp_emitted", emitted - e0, 6);
    $display("backpressure accepted_before_stall=%0d emitted=%0d", HELD, emitted - e0);

    // Reset with two ops in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a = rand_op(); b = rand_op();
    @(posedge clk); #1;
    a = rand_op(); b = rand_op();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_async_valid", out_valid, 1'b0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_no_stale", out_valid, 1'b0);
    end
    $display("reset mid-flight done");

    // Random traffic.
    nacc = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a = rand_op(); b = rand_op();
      @(negedge clk);
      if (in_valid && in_ready) nacc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    $display("random accepted=%0d total_emitted=%0d", nacc, emitted);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
